// File: rtl/cop0_exc_ctrl_if.sv
// Pipeline/COP0 side signals of the exception sequencer.
// The master modport is the pipeline and COP0 side; the slave modport is cop0_exc_ctrl.
interface cop0_exc_ctrl_if;
  logic [6:0]  iIrq;
  logic [6:0]  iIrqAck;
  logic [7:0]  oPendingInterrupt;
  logic [7:0]  iInterruptMask;
  logic        iExcLevel;
  logic        iInstrValid;
  logic [31:0] iPC;
  logic        iInBranchDelay;
  logic        iOverflow;
  logic        iSyscall;
  logic        iBreak;
  logic        iReservedInstr;
  logic        iAddrErrLoad;
  logic        iAddrErrStore;
  logic        iEretInstr;
  logic        oInstrKill;
  logic        oExcOccurred;
  logic [4:0]  oExcCode;
  logic        oBranchDelay;
  logic [31:0] oEPC;
  logic        oPCRedirect;
  logic [31:0] oPCTarget;
  logic        oEret;

  modport master (
    output iIrq, iIrqAck, iInterruptMask, iExcLevel, iInstrValid, iPC, iInBranchDelay,
           iOverflow, iSyscall, iBreak, iReservedInstr, iAddrErrLoad, iAddrErrStore, iEretInstr,
    input  oPendingInterrupt, oInstrKill, oExcOccurred, oExcCode, oBranchDelay, oEPC,
           oPCRedirect, oPCTarget, oEret
  );

  modport slave (
    input  iIrq, iIrqAck, iInterruptMask, iExcLevel, iInstrValid, iPC, iInBranchDelay,
           iOverflow, iSyscall, iBreak, iReservedInstr, iAddrErrLoad, iAddrErrStore, iEretInstr,
    output oPendingInterrupt, oInstrKill, oExcOccurred, oExcCode, oBranchDelay, oEPC,
           oPCRedirect, oPCTarget, oEret
  );
endinterface

// File: rtl/cop0_exc_ctrl.sv
// Exception/interrupt sequencer for COP0: IRQ synchronization and pending latch,
// synchronous-exception prioritization, trap strobe, handler redirect and ERET.
module cop0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR    = 32'h8000_0180,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input logic           iCLK,
  input logic           iCLR,
  cop0_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, TRAP, HANDLER} state_t;

  logic [IRQ_SYNC_STAGES-1:0][6:0] sync_q, sync_d;
  logic [6:0]  prev_q, prev_d;
  logic [6:0]  pending_q, pending_d;
  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;

  logic        sync_exc;
  logic        sys_or_bp;
  logic [4:0]  sync_code;
  logic        int_req;
  logic        eret_as_ri;

  always_ff @(posedge iCLK or posedge iCLR) begin
    if (iCLR) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      state_q   <= RUN;
      code_q    <= '0;
      bd_q      <= 1'b0;
      epc_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      code_q    <= code_d;
      bd_q      <= bd_d;
      epc_q     <= epc_d;
    end
  end

  // Rising edge of the synchronized line sets pending; a same-cycle ack loses.
  always_comb begin
    sync_d    = {sync_q[IRQ_SYNC_STAGES-2:0], bus.iIrq};
    prev_d    = sync_q[IRQ_SYNC_STAGES-1];
    pending_d = (pending_q & ~bus.iIrqAck) | (sync_q[IRQ_SYNC_STAGES-1] & ~prev_q);
  end

  assign bus.oPendingInterrupt = {1'b0, pending_q};

  assign eret_as_ri = bus.iEretInstr & (state_q != HANDLER);
  assign int_req    = (|bus.iInterruptMask) & ~bus.iExcLevel;

  always_comb begin
    sync_exc  = 1'b1;
    sys_or_bp = 1'b0;
    sync_code = 5'd0;
    if (bus.iAddrErrLoad)                         sync_code = 5'd4;
    else if (bus.iReservedInstr || eret_as_ri)    sync_code = 5'd10;
    else if (bus.iSyscall) begin                  sync_code = 5'd8;  sys_or_bp = 1'b1; end
    else if (bus.iBreak) begin                    sync_code = 5'd9;  sys_or_bp = 1'b1; end
    else if (bus.iOverflow)                       sync_code = 5'd12;
    else if (bus.iAddrErrStore)                   sync_code = 5'd5;
    else                                          sync_exc  = 1'b0;
  end

  always_comb begin
    state_d          = state_q;
    code_d           = code_q;
    bd_d             = bd_q;
    epc_d            = epc_q;
    bus.oInstrKill   = 1'b0;
    bus.oExcOccurred = 1'b0;
    bus.oExcCode     = 5'd0;
    bus.oBranchDelay = 1'b0;
    bus.oEPC         = 32'd0;
    bus.oPCRedirect  = 1'b0;
    bus.oPCTarget    = 32'd0;
    bus.oEret        = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.iInstrValid && (sync_exc || int_req)) begin
          bus.oInstrKill = 1'b1;
          code_d  = sync_exc ? sync_code : 5'd0;
          bd_d    = bus.iInBranchDelay;
          // Sys/Bp resume after the trapping instruction; everything else re-executes it.
          epc_d   = (!bus.iInBranchDelay && sys_or_bp) ? bus.iPC : bus.iPC - 32'd4;
          state_d = TRAP;
        end
      end
      TRAP: begin
        bus.oExcOccurred = 1'b1;
        bus.oExcCode     = code_q;
        bus.oBranchDelay = bd_q;
        bus.oEPC         = epc_q;
        bus.oPCRedirect  = 1'b1;
        bus.oPCTarget    = HANDLER_ADDR;
        bus.oInstrKill   = 1'b1;
        state_d          = HANDLER;
      end
      HANDLER: begin
        // Nested exceptions re-enter the handler without touching EPC/BD in COP0.
        if (bus.iInstrValid && sync_exc) begin
          bus.oInstrKill  = 1'b1;
          bus.oPCRedirect = 1'b1;
          bus.oPCTarget   = HANDLER_ADDR;
        end else if (bus.iInstrValid && bus.iEretInstr) begin
          bus.oEret = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_cop0_exc_ctrl.sv
// Directed self-checking bench for cop0_exc_ctrl with hand-computed expectations.
module tb_cop0_exc_ctrl;
  logic iCLK;
  logic iCLR;
  int   n_checks;
  int   n_fail;

  cop0_exc_ctrl_if bus();

  cop0_exc_ctrl #(.HANDLER_ADDR(32'h8000_0180), .IRQ_SYNC_STAGES(2)) dut (
    .iCLK (iCLK),
    .iCLR (iCLR),
    .bus  (bus.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic clear_flags();
    bus.iInstrValid = 1'b0; bus.iInBranchDelay = 1'b0; bus.iOverflow = 1'b0;
    bus.iSyscall = 1'b0; bus.iBreak = 1'b0; bus.iReservedInstr = 1'b0;
    bus.iAddrErrLoad = 1'b0; bus.iAddrErrStore = 1'b0; bus.iEretInstr = 1'b0;
    bus.iInterruptMask = 8'h00;
  endtask

  // Apply a valid instruction in RUN, check kill now and the trap strobe next cycle.
  task automatic trap_check(input string tag, input logic [31:0] pc, input logic [4:0] code,
                            input logic [31:0] epc, input logic bd);
    bus.iInstrValid = 1'b1; bus.iPC = pc; #1;
    check_val({tag, " kill"}, 32'(bus.oInstrKill), 32'd1);
    tick();
    clear_flags();
    check_val({tag, " exc"}, 32'(bus.oExcOccurred), 32'd1);
    check_val({tag, " code"}, 32'(bus.oExcCode), 32'(code));
    check_val({tag, " epc"}, bus.oEPC, epc);
    check_val({tag, " bd"}, 32'(bus.oBranchDelay), 32'(bd));
    check_val({tag, " redir"}, 32'(bus.oPCRedirect), 32'd1);
    check_val({tag, " target"}, bus.oPCTarget, 32'h8000_0180);
    tick();
    check_val({tag, " exc drop"}, 32'(bus.oExcOccurred), 32'd0);
  endtask

  // From HANDLER, issue ERET and confirm the one-cycle strobe.
  task automatic do_eret(input string tag);
    bus.iInstrValid = 1'b1; bus.iEretInstr = 1'b1; #1;
    check_val({tag, " eret"}, 32'(bus.oEret), 32'd1);
    tick();
    clear_flags();
    #1;
    check_val({tag, " eret drop"}, 32'(bus.oEret), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    iCLR = 1'b1;
    bus.iIrq = 7'h00; bus.iIrqAck = 7'h00; bus.iExcLevel = 1'b0; bus.iPC = 32'h0;
    clear_flags();
    tick(); tick();
    iCLR = 1'b0;
    #1;
    check_val("rst pending", 32'(bus.oPendingInterrupt), 32'h00);
    check_val("rst kill", 32'(bus.oInstrKill), 32'd0);
    check_val("rst exc", 32'(bus.oExcOccurred), 32'd0);
    check_val("rst code", 32'(bus.oExcCode), 32'd0);
    check_val("rst epc", bus.oEPC, 32'd0);
    check_val("rst redir", 32'(bus.oPCRedirect), 32'd0);

    // IRQ latency, ack, and set-beats-ack
    bus.iIrq = 7'h04;
    tick(); tick();
    check_val("irq 2 edges", 32'(bus.oPendingInterrupt), 32'h00);
    tick();
    check_val("irq 3 edges", 32'(bus.oPendingInterrupt), 32'h04);
    bus.iIrq = 7'h00;
    bus.iIrqAck = 7'h04;
    tick();
    bus.iIrqAck = 7'h00;
    check_val("irq ack", 32'(bus.oPendingInterrupt), 32'h00);
    bus.iIrq = 7'h04;
    tick(); tick();
    bus.iIrqAck = 7'h04;
    tick();
    bus.iIrqAck = 7'h00;
    check_val("irq set wins", 32'(bus.oPendingInterrupt), 32'h04);
    tick();
    check_val("irq held", 32'(bus.oPendingInterrupt), 32'h04);
    bus.iIrqAck = 7'h04;
    tick();
    bus.iIrqAck = 7'h00;
    bus.iIrq = 7'h00;
    check_val("irq clear", 32'(bus.oPendingInterrupt), 32'h00);

    // Overflow: EPC = PC-4
    bus.iOverflow = 1'b1;
    trap_check("ov", 32'h0040_0010, 5'd12, 32'h0040_000C, 1'b0);
    do_eret("ov");

    // Syscall in delay slot, then nested exception and masked interrupts in HANDLER
    bus.iSyscall = 1'b1; bus.iInBranchDelay = 1'b1;
    trap_check("sys bd", 32'h0040_0020, 5'd8, 32'h0040_001C, 1'b1);
    bus.iInstrValid = 1'b1; bus.iOverflow = 1'b1; #1;
    check_val("hdl nest redir", 32'(bus.oPCRedirect), 32'd1);
    check_val("hdl nest kill", 32'(bus.oInstrKill), 32'd1);
    check_val("hdl nest exc", 32'(bus.oExcOccurred), 32'd0);
    tick();
    clear_flags();
    bus.iInstrValid = 1'b1; bus.iInterruptMask = 8'hFF; #1;
    check_val("hdl int kill", 32'(bus.oInstrKill), 32'd0);
    tick();
    check_val("hdl int exc", 32'(bus.oExcOccurred), 32'd0);
    clear_flags();
    do_eret("sys");

    // Syscall not in delay slot: EPC = PC
    bus.iSyscall = 1'b1;
    trap_check("sys", 32'h0040_0050, 5'd8, 32'h0040_0050, 1'b0);
    do_eret("sys2");

    // Interrupt trap, invalid cycles first
    bus.iInterruptMask = 8'h01; bus.iPC = 32'h0040_0040; #1;
    check_val("int invalid kill", 32'(bus.oInstrKill), 32'd0);
    tick();
    check_val("int invalid exc", 32'(bus.oExcOccurred), 32'd0);
    bus.iInterruptMask = 8'h01;
    trap_check("int", 32'h0040_0040, 5'd0, 32'h0040_003C, 1'b0);
    do_eret("int");

    // Interrupt masked by exception level
    bus.iInterruptMask = 8'h01; bus.iExcLevel = 1'b1; bus.iInstrValid = 1'b1; #1;
    check_val("exl kill", 32'(bus.oInstrKill), 32'd0);
    bus.iExcLevel = 1'b0;
    clear_flags();

    // Sync exception beats interrupt
    bus.iInterruptMask = 8'h01; bus.iReservedInstr = 1'b1;
    trap_check("ri+int", 32'h0040_0030, 5'd10, 32'h0040_002C, 1'b0);
    do_eret("ri");

    // AdEL beats Syscall; PC=0 wraps
    bus.iAddrErrLoad = 1'b1; bus.iSyscall = 1'b1;
    trap_check("adel wrap", 32'h0000_0000, 5'd4, 32'hFFFF_FFFC, 1'b0);
    do_eret("adel");

    // Break beats Overflow; Overflow beats AdES
    bus.iBreak = 1'b1; bus.iOverflow = 1'b1;
    trap_check("bp", 32'h0040_0060, 5'd9, 32'h0040_0060, 1'b0);
    do_eret("bp");
    bus.iOverflow = 1'b1; bus.iAddrErrStore = 1'b1;
    trap_check("ov>ades", 32'h0040_0070, 5'd12, 32'h0040_006C, 1'b0);
    do_eret("ov2");
    bus.iAddrErrStore = 1'b1;
    trap_check("ades", 32'h0040_0080, 5'd5, 32'h0040_007C, 1'b0);
    do_eret("ades");

    // ERET outside HANDLER is reserved instruction
    bus.iEretInstr = 1'b1;
    trap_check("eret run", 32'h0040_0090, 5'd10, 32'h0040_008C, 1'b0);
    do_eret("eret run");

    // Reset during TRAP, with a pending interrupt latched beforehand
    bus.iIrq = 7'h20;
    tick(); tick(); tick();
    check_val("irq5 pend", 32'(bus.oPendingInterrupt), 32'h20);
    bus.iIrq = 7'h00;
    bus.iOverflow = 1'b1; bus.iInstrValid = 1'b1; bus.iPC = 32'h0040_00A0;
    tick();
    clear_flags();
    check_val("pre-rst exc", 32'(bus.oExcOccurred), 32'd1);
    iCLR = 1'b1; #1;
    check_val("rst trap exc", 32'(bus.oExcOccurred), 32'd0);
    check_val("rst trap redir", 32'(bus.oPCRedirect), 32'd0);
    tick();
    iCLR = 1'b0; #1;
    check_val("post-rst pending", 32'(bus.oPendingInterrupt), 32'h00);
    // Strobe on a fresh exception proves the FSM is back in RUN
    bus.iSyscall = 1'b1;
    trap_check("post-rst run", 32'h0040_00B0, 5'd8, 32'h0040_00B0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cop0_exc_ctrl.md
# cop0_exc_ctrl

Exception and interrupt sequencer for the uniprocessor MIPS core, driving the coprocessor-0 register file from the pipeline side. It synchronizes and latches external interrupt requests into the pending-interrupt vector that COP0 consumes. It also detects and prioritizes synchronous exceptions, kills the faulting instruction and produces the exception pulse, cause code, branch-delay flag and EPC value. It redirects fetch to the handler and sequences ERET back to user mode.

## Interface
Parameters:
- HANDLER_ADDR, 32'h8000_0180, exception vector address.
- IRQ_SYNC_STAGES, 2, synchronizer depth per IRQ line (≥2).

Ports:
- iCLK  in  1  clock
- iCLR  in  1  reset: asynchronous, active-high, clock iCLK
- iIrq  in  7  asynchronous external interrupt lines, active-high
- iIrqAck  in  7  one-cycle software clear, per bit
- oPendingInterrupt  out  8  to COP0 pending input; bit 7 constant 0 (timer owned by COP0)
- iInterruptMask  in  8  enabled-and-pending vector from COP0
- iExcLevel  in  1  COP0 exception-level bit
- iInstrValid  in  1  current instruction is valid
- iPC  in  32  address of current instruction
- iInBranchDelay  in  1  current instruction sits in a branch delay slot
- iOverflow, iSyscall, iBreak, iReservedInstr, iAddrErrLoad, iAddrErrStore, iEretInstr  in  1 each  decode/execute flags
- oInstrKill  out  1  suppress all architectural writes of the current instruction
- oExcOccurred  out  1  one-cycle exception strobe to COP0
- oExcCode  out  5  cause code
- oBranchDelay  out  1  BD flag to COP0
- oEPC  out  32  EPC value (presented on COP0 write-data path with oExcOccurred)
- oPCRedirect  out  1  force next PC
- oPCTarget  out  32  next-PC value when redirecting
- oEret  out  1  ERET strobe to COP0

## Operation
- IRQ path: each line passes through an IRQ_SYNC_STAGES flop synchronizer. A rising edge of the synchronized line sets pending[i]. iIrqAck[i] clears it. Simultaneous set and ack on the same bit: set wins.
- Cause codes: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
- Priority, highest first: AdEL, RI, Sys, Bp, Ov, AdES, Int.
- iEretInstr outside HANDLER counts as RI.
- FSM states: RUN, TRAP, HANDLER.
- RUN transitions:
  - A synchronous exception, or an interrupt (|iInterruptMask, iExcLevel=0), with iInstrValid=1 asserts oInstrKill combinationally.
  - Code, BD and EPC are registered in that cycle, and the FSM moves to TRAP.
- EPC rules:
  - iInBranchDelay=1: EPC = iPC−4, BD=1.
  - Otherwise Sys/Bp: EPC = iPC, BD=0 (returns to iPC+4).
  - Otherwise all other codes: EPC = iPC−4, BD=0 (returns to iPC, re-execute).
  - Arithmetic is 32-bit modulo: iPC=0 gives EPC 32'hFFFF_FFFC.
- TRAP lasts one cycle:
  - oExcOccurred=1, with registered oExcCode, oBranchDelay and oEPC.
  - oPCRedirect=1, oPCTarget=HANDLER_ADDR, oInstrKill=1.
  - Next state: HANDLER.
- HANDLER transitions:
  - Interrupts are ignored.
  - A synchronous exception kills the instruction and sets oPCRedirect=1 to HANDLER_ADDR in the same cycle. oExcOccurred stays 0, so EPC and BD in COP0 are preserved. State stays HANDLER.
  - iEretInstr & iInstrValid (with no higher-priority exception) asserts oEret=1 combinationally and the FSM returns to RUN next edge. The PC target comes from the COP0 read path, not from this block.
- Outputs not named in a state are 0.

## Timing
- Reset values:
  - state RUN.
  - pending, synchronizers, oPendingInterrupt: 0.
  - All outputs 0; oEPC and oExcCode 0.
- IRQ latency: the edge on iIrq appears on oPendingInterrupt IRQ_SYNC_STAGES+1 edges later.
- Exception latency:
  - oInstrKill: same cycle.
  - oExcOccurred and oPCRedirect: exactly the next cycle.
  - Handler fetch: the cycle after TRAP.
- iInstrValid=0 in RUN: no trap, even when an interrupt is pending. The trap is taken on the first valid cycle.
- Reset mid-TRAP: the strobe is aborted immediately and the FSM returns to RUN.
- Interrupt and synchronous exception in the same cycle: the synchronous code wins, and the interrupt is retaken after ERET.

## Test plan
- Pulse iIrq[2] high for 3 cycles → oPendingInterrupt=8'h04 after 3 edges. iIrqAck[2] → 8'h00 next edge. Ack and a new edge in the same cycle → stays 8'h04.
- RUN, iPC=32'h0040_0010, iOverflow=1 → oInstrKill=1 that cycle. Next cycle: oExcOccurred=1, oExcCode=12, oEPC=32'h0040_000C, oBranchDelay=0, oPCTarget=32'h8000_0180.
- iSyscall at iPC=32'h0040_0020, iInBranchDelay=1 → oExcCode=8, oEPC=32'h0040_001C, oBranchDelay=1.
- iInterruptMask=8'h01 plus iReservedInstr at iPC=32'h0040_0030 → oExcCode=10, not 0.
- In HANDLER: iOverflow → oPCRedirect=1, oExcOccurred stays 0. iInterruptMask=8'hFF → no trap. iEretInstr valid → oEret=1 for one cycle, FSM in RUN next cycle.
- iCLR asserted during TRAP → oExcOccurred and oPCRedirect drop asynchronously. After release, oPendingInterrupt=0 and the FSM is in RUN.
